// File: rtl/merge_table_flattener.sv
// merge_table_flattener
// Runs the end-of-frame pass over the connected-components merge table.
// Labels 1..num_labels-1 are visited in ascending order. Each entry is
// rewritten to point straight at its root label, and the roots are counted.
//
// Ports:
//   clk, reset   - system clock, asynchronous active-high reset
//   start        - frame-end pulse, accepted only in IDLE
//   num_labels   - next-free label count, latched on an accepted start
//   busy, stall  - pass in progress (stall gates the pixel labeler)
//   done         - one-cycle pulse when the pass completes
//   num_objects  - number of root labels found in the last pass
//   error        - sticky flag for invalid table entries (p==0 or p>i)
//   rd_addr      - merge-table read address (registered-read memory)
//   rd_data      - merge-table read data, one cycle after rd_addr
//   wr_en, wr_addr, wr_data - merge-table write port
module merge_table_flattener #(
  parameter int WORD_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WORD_SIZE-1:0] num_labels,
  output logic                 busy,
  output logic                 stall,
  output logic                 done,
  output logic [WORD_SIZE-1:0] num_objects,
  output logic                 error,
  output logic [WORD_SIZE-1:0] rd_addr,
  input  logic [WORD_SIZE-1:0] rd_data,
  output logic                 wr_en,
  output logic [WORD_SIZE-1:0] wr_addr,
  output logic [WORD_SIZE-1:0] wr_data
);

  localparam logic [WORD_SIZE-1:0] ZERO = {WORD_SIZE{1'b0}};
  localparam logic [WORD_SIZE-1:0] ONE  = {{(WORD_SIZE-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_I  = 3'd1,
    CAP_I = 3'd2,
    CAP_P = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [WORD_SIZE-1:0] idx;
  logic [WORD_SIZE-1:0] lim;
  logic [WORD_SIZE-1:0] rd_addr_hold;
  logic                 accept;
  logic                 inc_idx;
  logic                 obj_inc;
  logic                 err_set;
  logic                 last;

  assign last  = (idx == (lim - ONE));
  assign stall = busy;

  // Next-state, read-address mux and write-port decode.
  // The read address is combinational so that the parent lookup in CAP_I
  // reaches the memory in the same cycle; rd_data then arrives in CAP_P.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    inc_idx    = 1'b0;
    obj_inc    = 1'b0;
    err_set    = 1'b0;
    rd_addr    = rd_addr_hold;
    wr_en      = 1'b0;
    wr_addr    = idx;
    wr_data    = idx;
    case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (num_labels <= ONE) begin
            state_next = DONE;
          end else begin
            state_next = RD_I;
          end
        end else begin
          state_next = IDLE;
        end
      end
      RD_I: begin
        rd_addr    = idx;
        state_next = CAP_I;
      end
      CAP_I: begin
        if (rd_data == idx) begin
          obj_inc    = 1'b1;
          inc_idx    = ~last;
          state_next = last ? DONE : RD_I;
        end else if ((rd_data == ZERO) || (rd_data > idx)) begin
          // Corrupt entry: repair it as a self-root and count it.
          err_set    = 1'b1;
          wr_en      = 1'b1;
          wr_data    = idx;
          obj_inc    = 1'b1;
          inc_idx    = ~last;
          state_next = last ? DONE : RD_I;
        end else begin
          rd_addr    = rd_data;
          state_next = CAP_P;
        end
      end
      CAP_P: begin
        // Parent p<i is already flattened, so t[p] is the root.
        wr_en      = 1'b1;
        wr_data    = rd_data;
        inc_idx    = ~last;
        state_next = last ? DONE : RD_I;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, index, latched count and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= ZERO;
      lim          <= ZERO;
      rd_addr_hold <= ZERO;
      busy         <= 1'b0;
      done         <= 1'b0;
      num_objects  <= ZERO;
      error        <= 1'b0;
    end else begin
      state        <= state_next;
      rd_addr_hold <= rd_addr;
      busy         <= (state_next != IDLE);
      done         <= (state == DONE);
      if (accept) begin
        idx <= ONE;
        lim <= num_labels;
      end else if (inc_idx) begin
        idx <= idx + ONE;
      end else begin
        idx <= idx;
      end
      if (accept) begin
        num_objects <= ZERO;
      end else if (obj_inc) begin
        num_objects <= num_objects + ONE;
      end else begin
        num_objects <= num_objects;
      end
      if (accept) begin
        error <= 1'b0;
      end else if (err_set) begin
        error <= 1'b1;
      end else begin
        error <= error;
      end
    end
  end

endmodule

// File: doc/merge_table_flattener.md
Name: merge_table_flattener

Overview:
- Sequences the end-of-frame resolution pass over the label merge table that the connected-components labeler fills during a frame.
- After the last pixel of a frame, it walks labels 1..num_labels-1 in ascending order. Each entry is rewritten to point directly at its root label, so a single table lookup gives the final component ID.
- It owns the merge-table read address and write port while busy, and stalls the pixel labeler for the duration of the pass.
- It also reports the number of distinct components (roots).

Parameters:
- WORD_SIZE, 8, width of labels, merge-table addresses and merge-table data.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse at frame end; sampled only in IDLE.
- num_labels  input  WORD_SIZE  next-free label count from the labeler; label 0 is reserved. Latched on accepted start.
- busy  output  1  high from the cycle after an accepted start until the cycle the done pulse is issued.
- stall  output  1  equals busy; the labeler's en input is driven from ~stall.
- done  output  1  one-cycle pulse when the pass completes.
- num_objects  output  WORD_SIZE  count of root labels found; valid from the done pulse until the next accepted start.
- error  output  1  sticky until next accepted start; set on an invalid table entry.
- rd_addr  output  WORD_SIZE  merge-table read address.
- rd_data  input  WORD_SIZE  merge-table read data; one-cycle registered-read latency.
- wr_en  output  1  merge-table write enable; high for exactly one cycle per rewrite.
- wr_addr  output  WORD_SIZE  merge-table write address.
- wr_data  output  WORD_SIZE  merge-table write data.

Behaviour:
- Reset (asynchronous, immediate):
  - Outputs: busy=0, stall=0, done=0, wr_en=0, error=0, num_objects=0, rd_addr=0.
  - Internal state: FSM=IDLE, index i=0, latched count L=0.
- Reset mid-pass: the pass is abandoned and no further writes are made. A partially flattened table is acceptable; the next start restarts from label 1.
- States: IDLE, RD_I, CAP_I, CAP_P, DONE.
- IDLE: start=1 latches L=num_labels and clears num_objects and error.
  - If L<=1, go to DONE (empty frame, num_objects=0).
  - Otherwise set i=1 and go to RD_I.
  - start is ignored in every other state.
- RD_I: drive rd_addr=i; go to CAP_I.
- CAP_I: let p=rd_data.
  - Root (p==i): increment num_objects; advance.
  - Invalid (p==0 or p>i): set error; write wr_addr=i, wr_data=i; increment num_objects (treated as a root); advance.
  - Non-root (0<p<i): drive rd_addr=p; go to CAP_P.
- CAP_P: write wr_addr=i, wr_data=rd_data; advance.
  - Correctness relies on ascending order: entry p<i has already been flattened, so t[p] is a root.
- Advance: if i==L-1, go to DONE; otherwise i=i+1 and go to RD_I.
- DONE: done=1 for one cycle; busy and stall drop to 0 in this same cycle; go to IDLE.
  - A start in the cycle after DONE is accepted normally.
- Cycle cost per label: 2 cycles for a root or invalid entry, 3 cycles for a non-root.
  - Total = 2 (start acceptance plus DONE) + sum of per-label cycles.
  - done asserts exactly that many cycles after the start cycle.
- Timing: rd_addr is registered or combinational from state. rd_data is always sampled exactly one cycle after its address was driven.
- Width: num_objects is WORD_SIZE bits and cannot overflow, since there are at most 2^WORD_SIZE-1 labels. i never reaches L.
- Outside RD_I and CAP_I, rd_addr holds its last value. wr_en=0 except in the write cycles listed above.

Test Plan:
- Reset during busy → busy=0, stall=0 and wr_en=0 immediately (asynchronous). A following start with table {1:1, 2:1}, num_labels=3 → done, num_objects=1, t[2]=1.
- Empty frame: start with num_labels=1 → done pulses 2 cycles after start, num_objects=0, no wr_en, busy high for exactly 1 cycle.
- Chain table {1:1, 2:1, 3:2, 4:3, 5:5}, num_labels=6 → final table {1,1,1,1,5}, num_objects=2. Exactly 3 writes, to addresses 2,3,4 with data 1,1,1. done at cycle 2+2+3+3+3+2=15 after start.
- All roots {1:1, 2:2, 3:3}, num_labels=4 → no writes, num_objects=3, done 8 cycles after start.
- Invalid entries {1:1, 2:0, 3:7}, num_labels=4 → error=1, t[2]=2, t[3]=3, num_objects=3. error clears on the next accepted start.
- start re-asserted while busy and on the DONE cycle → ignored, single done pulse. start on the cycle after done → new pass begins, busy rises next cycle.
